// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the round-robin memory arbiter: request field layout,
// command encodings, lane widths and the arbiter state encoding.
package mem_arbiter_pkg;

  localparam int REQ_W    = 25;
  localparam int INV_W    = 16;
  localparam int RESP_W   = 16;
  localparam int CMD_BIT  = 24;
  localparam int ADDR_MSB = 15;
  localparam int ADDR_LSB = 0;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_MEM = 2'd1,
    ST_RELEASE  = 2'd2
  } arb_state_e;

  function automatic logic [INV_W-1:0] req_addr(input logic [REQ_W-1:0] req);
    return req[ADDR_MSB:ADDR_LSB];
  endfunction

  function automatic logic req_is_write(input logic [REQ_W-1:0] req);
    return (req[CMD_BIT] == CMD_WRITE);
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// Combinational round-robin picker: first asserted request at or above rr_ptr,
// wrapping at NUM_PORTS.
module mem_arbiter_rr_picker #(
  parameter int NUM_PORTS = 2,
  parameter int PTR_W     = 1
) (
  input  logic [NUM_PORTS-1:0] request_valid,
  input  logic [PTR_W-1:0]     rr_ptr,
  output logic [PTR_W-1:0]     grant,
  output logic                 any_valid
);

  logic [PTR_W:0] sum_s;
  logic [PTR_W:0] idx_s;
  logic           hit_s;

  // Walk the ports starting at rr_ptr; the first hit is held for the rest of the scan.
  always_comb begin
    grant     = '0;
    any_valid = 1'b0;
    sum_s     = '0;
    idx_s     = '0;
    hit_s     = 1'b0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      sum_s     = (PTR_W+1)'(rr_ptr) + (PTR_W+1)'(k);
      idx_s     = (sum_s >= (PTR_W+1)'(NUM_PORTS)) ? (sum_s - (PTR_W+1)'(NUM_PORTS)) : sum_s;
      hit_s     = request_valid[idx_s[PTR_W-1:0]] & ~any_valid;
      grant     = hit_s ? idx_s[PTR_W-1:0] : grant;
      any_valid = any_valid | hit_s;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port among NUM_PORTS caches, with
// write-invalidate broadcast. Optional watchdog enabled by MEM_ARB_TIMEOUT_EN.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int NUM_PORTS      = 2,
  parameter int PTR_W          = 1,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_PORTS*REQ_W-1:0] cache_request,
  input  logic [NUM_PORTS-1:0]       cache_request_ready,
  output logic [RESP_W-1:0]          cache_response,
  output logic [NUM_PORTS-1:0]       cache_response_ready,
  output logic [NUM_PORTS*INV_W-1:0] invalidate_address,
  output logic [REQ_W-1:0]           memory_request,
  output logic                       memory_request_ready,
  input  logic [RESP_W-1:0]          memory_response,
  input  logic                       memory_response_ready,
  output logic                       timeout_error
);

  if (NUM_PORTS < 2 || NUM_PORTS > 8 || PTR_W < $clog2(NUM_PORTS) || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("mem_arbiter: illegal parameter combination");
  end

  arb_state_e                       state_r, state_s;
  logic [PTR_W-1:0]                 rr_ptr_r, rr_ptr_s;
  logic [PTR_W-1:0]                 grant_r, grant_s;
  logic [PTR_W-1:0]                 pick_grant_s;
  logic                             pick_valid_s;
  logic [REQ_W-1:0]                 mem_req_r, mem_req_s;
  logic                             mem_req_rdy_r, mem_req_rdy_s;
  logic [RESP_W-1:0]                resp_r, resp_s;
  logic [NUM_PORTS-1:0]             resp_rdy_r, resp_rdy_s;
  logic [NUM_PORTS-1:0][INV_W-1:0]  inv_r, inv_s;
  logic [NUM_PORTS-1:0]             fix_mask_r, fix_mask_s;
  logic [INV_W-1:0]                 wr_addr_s;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] tmo_cnt_r, tmo_cnt_s;
  logic             tmo_err_r, tmo_err_s;
`endif

  mem_arbiter_rr_picker #(
    .NUM_PORTS (NUM_PORTS),
    .PTR_W     (PTR_W)
  ) u_picker (
    .request_valid (cache_request_ready),
    .rr_ptr        (rr_ptr_r),
    .grant         (pick_grant_s),
    .any_valid     (pick_valid_s)
  );

  // Next-state and next-output logic for the IDLE / WAIT_MEM / RELEASE sequence.
  always_comb begin
    state_s       = state_r;
    rr_ptr_s      = rr_ptr_r;
    grant_s       = grant_r;
    mem_req_s     = mem_req_r;
    mem_req_rdy_s = mem_req_rdy_r;
    resp_s        = resp_r;
    resp_rdy_s    = '0;
    inv_s         = inv_r;
    fix_mask_s    = '0;
    wr_addr_s     = req_addr(mem_req_r);
`ifdef MEM_ARB_TIMEOUT_EN
    tmo_cnt_s     = tmo_cnt_r;
    tmo_err_s     = tmo_err_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (pick_valid_s) begin
          grant_s       = pick_grant_s;
          mem_req_s     = cache_request[pick_grant_s*REQ_W +: REQ_W];
          mem_req_rdy_s = 1'b1;
          state_s       = ST_WAIT_MEM;
`ifdef MEM_ARB_TIMEOUT_EN
          tmo_cnt_s     = '0;
`endif
        end else begin
          mem_req_s     = '0;
          mem_req_rdy_s = 1'b0;
        end
      end
      ST_WAIT_MEM: begin
        if (memory_response_ready) begin
          resp_s              = memory_response;
          resp_rdy_s[grant_r] = 1'b1;
          mem_req_rdy_s       = 1'b0;
          state_s             = ST_RELEASE;
          // A lane already holding the address flips to ~A first so the change is visible.
          for (int j = 0; j < NUM_PORTS; j++) begin
            if (req_is_write(mem_req_r) && (PTR_W'(j) != grant_r)) begin
              if (inv_r[j] != wr_addr_s) begin
                inv_s[j] = wr_addr_s;
              end else begin
                inv_s[j]      = ~wr_addr_s;
                fix_mask_s[j] = 1'b1;
              end
            end else begin
              inv_s[j] = inv_r[j];
            end
          end
        end
`ifdef MEM_ARB_TIMEOUT_EN
        else if (tmo_cnt_r == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          tmo_err_s           = 1'b1;
          resp_s              = {RESP_W{1'b0}};
          resp_rdy_s[grant_r] = 1'b1;
          mem_req_rdy_s       = 1'b0;
          state_s             = ST_RELEASE;
        end else begin
          tmo_cnt_s = tmo_cnt_r + CNT_W'(1);
        end
`else
        else begin
          state_s = ST_WAIT_MEM;
        end
`endif
      end
      ST_RELEASE: begin
        rr_ptr_s = (grant_r == PTR_W'(NUM_PORTS - 1)) ? {PTR_W{1'b0}} : (grant_r + PTR_W'(1));
        state_s  = ST_IDLE;
        for (int j = 0; j < NUM_PORTS; j++) begin
          if (fix_mask_r[j]) begin
            inv_s[j] = wr_addr_s;
          end else begin
            inv_s[j] = inv_r[j];
          end
        end
      end
      default: begin
        state_s       = ST_IDLE;
        mem_req_rdy_s = 1'b0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath and output registers; reset drops any transaction in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr_r      <= '0;
      grant_r       <= '0;
      mem_req_r     <= '0;
      mem_req_rdy_r <= 1'b0;
      resp_r        <= '0;
      resp_rdy_r    <= '0;
      inv_r         <= '0;
      fix_mask_r    <= '0;
    end else begin
      rr_ptr_r      <= rr_ptr_s;
      grant_r       <= grant_s;
      mem_req_r     <= mem_req_s;
      mem_req_rdy_r <= mem_req_rdy_s;
      resp_r        <= resp_s;
      resp_rdy_r    <= resp_rdy_s;
      inv_r         <= inv_s;
      fix_mask_r    <= fix_mask_s;
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  // Watchdog counter and sticky error flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      tmo_cnt_r <= '0;
      tmo_err_r <= 1'b0;
    end else begin
      tmo_cnt_r <= tmo_cnt_s;
      tmo_err_r <= tmo_err_s;
    end
  end

  assign timeout_error = tmo_err_r;
`else
  assign timeout_error = 1'b0;
`endif

  assign memory_request       = mem_req_r;
  assign memory_request_ready = mem_req_rdy_r;
  assign cache_response       = resp_r;
  assign cache_response_ready = resp_rdy_r;
  assign invalidate_address   = inv_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed transactions, a memory model that
// checks forwarded requests, and a monitor that checks every response pulse.
`timescale 1ns/1ps
module tb_mem_arbiter;

  localparam int NP = 2;

  logic              clock = 1'b0;
  logic              reset;
  logic [NP*25-1:0]  cache_request;
  logic [NP-1:0]     cache_request_ready;
  logic [15:0]       cache_response;
  logic [NP-1:0]     cache_response_ready;
  logic [NP*16-1:0]  invalidate_address;
  logic [24:0]       memory_request;
  logic              memory_request_ready;
  logic [15:0]       memory_response;
  logic              memory_response_ready;
  logic              timeout_error;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct { logic [NP-1:0] rdy; logic [15:0] data; } resp_t;
  typedef struct { logic [24:0] req; logic [15:0] data; int lat; } mem_t;

  resp_t sb_q[$];
  mem_t  mem_q[$];

  always #5 clock = ~clock;

  mem_arbiter #(
    .NUM_PORTS      (NP),
    .PTR_W          (1),
    .TIMEOUT_CYCLES (64)
  ) dut (
    .clock                 (clock),
    .reset                 (reset),
    .cache_request         (cache_request),
    .cache_request_ready   (cache_request_ready),
    .cache_response        (cache_response),
    .cache_response_ready  (cache_response_ready),
    .invalidate_address    (invalidate_address),
    .memory_request        (memory_request),
    .memory_request_ready  (memory_request_ready),
    .memory_response       (memory_response),
    .memory_response_ready (memory_response_ready),
    .timeout_error         (timeout_error)
  );

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  task automatic set_req(input int p, input logic [24:0] r);
    cache_request[p*25 +: 25] = r;
    cache_request_ready[p]    = 1'b1;
  endtask

  task automatic wait_pulse(input string name);
    for (int k = 0; k < 300; k++) begin
      @(negedge clock);
      if (cache_response_ready != '0) break;
    end
    check({name, "_seen"}, 32'(cache_response_ready != '0), 32'd1);
  endtask

  // Response monitor: every pulse pops the scoreboard.
  initial begin
    resp_t         e;
    logic [NP-1:0] prev_rdy;
    prev_rdy = '0;
    forever begin
      @(negedge clock);
      if (reset !== 1'b1 && cache_response_ready != '0) begin
        check("pulse_width", 32'(prev_rdy), 32'd0);
        if (sb_q.size() == 0) begin
          check("unexpected_pulse", 32'(cache_response_ready), 32'd0);
        end else begin
          e = sb_q.pop_front();
          check("resp_ready", 32'(cache_response_ready), 32'(e.rdy));
          check("resp_data", 32'(cache_response), 32'(e.data));
        end
      end
      prev_rdy = (reset === 1'b1) ? '0 : cache_response_ready;
    end
  end

  // Memory model: checks the forwarded request, answers after the queued latency.
  initial begin
    mem_t        m;
    bit          busy;
    int          wait_n;
    logic [15:0] data;
    busy = 1'b0;
    wait_n = 0;
    data = 16'h0000;
    memory_response = 16'h0000;
    memory_response_ready = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      memory_response_ready = 1'b0;
      if (!busy && memory_request_ready === 1'b1 && mem_q.size() != 0) begin
        m = mem_q.pop_front();
        check("mem_req", 32'(memory_request), 32'(m.req));
        busy = 1'b1;
        wait_n = m.lat;
        data = m.data;
      end else if (busy && wait_n > 0) begin
        wait_n--;
      end
      if (busy && wait_n == 0) begin
        memory_response = data;
        memory_response_ready = 1'b1;
        busy = 1'b0;
      end
    end
  end

  initial begin
    int n_hi;
    reset = 1'b1;
    cache_request = '0;
    cache_request_ready = '0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("rst_mreq_rdy", 32'(memory_request_ready), 32'd0);
    check("rst_mreq", 32'(memory_request), 32'd0);
    check("rst_resp_rdy", 32'(cache_response_ready), 32'd0);
    check("rst_resp", 32'(cache_response), 32'd0);
    check("rst_inv", 32'(invalidate_address), 32'd0);
    check("rst_tmo", 32'(timeout_error), 32'd0);

    // Single read from port0
    mem_q.push_back('{25'h0000042, 16'hBEEF, 3});
    sb_q.push_back('{2'b01, 16'hBEEF});
    set_req(0, 25'h0000042);
    wait_pulse("read0");
    cache_request_ready[0] = 1'b0;
    check("read0_inv", 32'(invalidate_address), 32'h0000_0000);
    repeat (2) @(negedge clock);

    // Port1 write invalidates lane0
    mem_q.push_back('{25'h15A1234, 16'h5A00, 2});
    sb_q.push_back('{2'b10, 16'h5A00});
    set_req(1, 25'h15A1234);
    wait_pulse("wr1");
    cache_request_ready[1] = 1'b0;
    check("wr1_lane0", 32'(invalidate_address[15:0]), 32'h1234);
    check("wr1_lane1", 32'(invalidate_address[31:16]), 32'h0000);
    @(negedge clock);
    check("wr1_lane0_hold", 32'(invalidate_address[15:0]), 32'h1234);

    // Same write again: lane0 shows ~A for one cycle, then A
    mem_q.push_back('{25'h15A1234, 16'h5A00, 1});
    sb_q.push_back('{2'b10, 16'h5A00});
    set_req(1, 25'h15A1234);
    wait_pulse("wr1b");
    cache_request_ready[1] = 1'b0;
    check("wr1b_lane0_flip", 32'(invalidate_address[15:0]), 32'hEDCB);
    @(negedge clock);
    check("wr1b_lane0_final", 32'(invalidate_address[15:0]), 32'h1234);
    check("wr1b_lane1", 32'(invalidate_address[31:16]), 32'h0000);
    repeat (2) @(negedge clock);

    // Contention with rr_ptr=0; port0 re-requests during its RELEASE cycle
    mem_q.push_back('{25'h0000100, 16'h1111, 1});
    mem_q.push_back('{25'h0000200, 16'h2222, 1});
    mem_q.push_back('{25'h0000300, 16'h3333, 1});
    sb_q.push_back('{2'b01, 16'h1111});
    sb_q.push_back('{2'b10, 16'h2222});
    sb_q.push_back('{2'b01, 16'h3333});
    set_req(0, 25'h0000100);
    set_req(1, 25'h0000200);
    wait_pulse("cont_a");
    set_req(0, 25'h0000300);
    wait_pulse("cont_b");
    cache_request_ready[1] = 1'b0;
    wait_pulse("cont_c");
    cache_request_ready[0] = 1'b0;
    check("cont_inv", 32'(invalidate_address), 32'h0000_1234);
    repeat (2) @(negedge clock);

    // Port0 write with immediate memory answer; writer lane untouched
    mem_q.push_back('{25'h17700AB, 16'h7700, 0});
    sb_q.push_back('{2'b01, 16'h7700});
    set_req(0, 25'h17700AB);
    wait_pulse("wr0");
    cache_request_ready[0] = 1'b0;
    check("wr0_inv", 32'(invalidate_address), 32'h00AB_1234);
    repeat (2) @(negedge clock);

    // Reset during WAIT_MEM; the late memory answer must be ignored
    mem_q.push_back('{25'h0000555, 16'h5555, 4});
    set_req(1, 25'h0000555);
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (memory_request_ready === 1'b1) break;
    end
    check("rst_op_started", 32'(memory_request_ready), 32'd1);
    reset = 1'b1;
    cache_request_ready = '0;
    @(negedge clock);
    reset = 1'b0;
    check("rstop_mreq_rdy", 32'(memory_request_ready), 32'd0);
    check("rstop_mreq", 32'(memory_request), 32'd0);
    check("rstop_inv", 32'(invalidate_address), 32'd0);
    check("rstop_resp", 32'(cache_response), 32'd0);
    check("rstop_resp_rdy", 32'(cache_response_ready), 32'd0);
    repeat (8) @(negedge clock);
    check("late_mreq_rdy", 32'(memory_request_ready), 32'd0);
    check("late_mreq", 32'(memory_request), 32'd0);

    // rr_ptr back at 0 after reset: port0 wins
    mem_q.push_back('{25'h0000600, 16'h6666, 1});
    mem_q.push_back('{25'h0000700, 16'h7777, 1});
    sb_q.push_back('{2'b01, 16'h6666});
    sb_q.push_back('{2'b10, 16'h7777});
    set_req(0, 25'h0000600);
    set_req(1, 25'h0000700);
    wait_pulse("post_a");
    cache_request_ready[0] = 1'b0;
    wait_pulse("post_b");
    cache_request_ready[1] = 1'b0;
    repeat (2) @(negedge clock);

`ifdef MEM_ARB_TIMEOUT_EN
    // Silent memory: watchdog fires after 64 WAIT_MEM cycles
    sb_q.push_back('{2'b01, 16'h0000});
    set_req(0, 25'h0000042);
    n_hi = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clock);
      if (cache_response_ready != '0) break;
      if (memory_request_ready === 1'b1) n_hi++;
    end
    check("tmo_seen", 32'(cache_response_ready != '0), 32'd1);
    check("tmo_len", 32'(n_hi), 32'd64);
    check("tmo_flag", 32'(timeout_error), 32'd1);
    cache_request_ready[0] = 1'b0;
    repeat (2) @(negedge clock);
    check("tmo_sticky", 32'(timeout_error), 32'd1);
    check("tmo_idle", 32'(memory_request_ready), 32'd0);
`else
    n_hi = 0;
    check("tmo_off", 32'(timeout_error), 32'(n_hi));
`endif

    repeat (3) @(negedge clock);
    check("sb_empty", 32'(sb_q.size()), 32'd0);
    check("mem_empty", 32'(mem_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
